// File: rtl/key_pkg.sv
// +----------------------------------------------------------------------+
// | key_pkg: shared constants and helpers for the push-button front end   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

package key_pkg;

  localparam int CLK_HZ          = 50_000_000;
  localparam int DB_CYCLES_DEF   = 500_000;
  localparam int AUTO_CYCLES_DEF = 50_000_000;

  localparam int KEY_STEP = 0;
  localparam int KEY_MODE = 1;

  // Bits needed for a counter that runs 0..n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
// +----------------------------------------------------------------------+
// | key_debounce: 2-flop synchroniser, stability counter, press strobe    |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module key_debounce
  import key_pkg::*;
#(
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic key_n_i,
  output logic level_o,
  output logic press_o
);

  localparam int             CW      = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0]  DB_LAST = CW'(DB_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    press_d = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_LAST) begin
        level_d = ~level_q;
        // Only the released->pressed transition produces a strobe.
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_n_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;
  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/key_step_counter.sv
// +----------------------------------------------------------------------+
// | key_step_counter: debounced manual/auto step counter for board input  |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module key_step_counter
  import key_pkg::*;
#(
  parameter int CNT_W       = 3,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int AUTO_CYCLES = AUTO_CYCLES_DEF
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [1:0]       KEY_N,
  output logic [CNT_W-1:0] COUNT,
  output logic             STEP_PULSE,
  output logic             WRAP,
  output logic             AUTO_MODE
);

  localparam int            TW        = cnt_width(AUTO_CYCLES);
  localparam logic [TW-1:0] AUTO_LAST = TW'(AUTO_CYCLES - 1);

  logic [1:0]       press;
  logic [1:0]       level_unused;

  logic [CNT_W-1:0] count_q, count_d;
  logic             pulse_q, pulse_d;
  logic             wrap_q, wrap_d;
  logic             auto_q, auto_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             tick;
  logic             step;

  for (genvar k = 0; k < 2; k++) begin : g_key
    key_debounce #(
      .DB_CYCLES (DB_CYCLES)
    ) u_db (
      .clk_i   (CLK),
      .rst_i   (RST),
      .key_n_i (KEY_N[k]),
      .level_o (level_unused[k]),
      .press_o (press[k])
    );
  end

  always_comb begin
    tick    = auto_q && (timer_q == AUTO_LAST);
    // A manual press and an auto tick in the same cycle merge into one step.
    step    = press[KEY_STEP] | tick;
    auto_d  = auto_q ^ press[KEY_MODE];
    timer_d = '0;
    if (!press[KEY_MODE] && auto_q && !tick) begin
      timer_d = timer_q + TW'(1);
    end
    count_d = step ? count_q + CNT_W'(1) : count_q;
    pulse_d = step;
    wrap_d  = step && (count_q == '1);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      count_q <= '0;
      pulse_q <= 1'b0;
      wrap_q  <= 1'b0;
      auto_q  <= 1'b0;
      timer_q <= '0;
    end else begin
      count_q <= count_d;
      pulse_q <= pulse_d;
      wrap_q  <= wrap_d;
      auto_q  <= auto_d;
      timer_q <= timer_d;
    end
  end

  assign COUNT      = count_q;
  assign STEP_PULSE = pulse_q;
  assign WRAP       = wrap_q;
  assign AUTO_MODE  = auto_q;

endmodule

`default_nettype wire

// File: tb/tb_key_step_counter.sv
// +----------------------------------------------------------------------+
// | tb_key_step_counter: directed self-checking bench, DB=4, AUTO=10      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_key_step_counter;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] KEY_N = 2'b11;
  logic [2:0] COUNT;
  logic       STEP_PULSE;
  logic       WRAP;
  logic       AUTO_MODE;

  int         checks = 0;
  int         errors = 0;
  logic [2:0] exp_count = 3'd0;

  key_step_counter #(
    .CNT_W       (3),
    .DB_CYCLES   (4),
    .AUTO_CYCLES (10)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .KEY_N      (KEY_N),
    .COUNT      (COUNT),
    .STEP_PULSE (STEP_PULSE),
    .WRAP       (WRAP),
    .AUTO_MODE  (AUTO_MODE)
  );

  always #5 CLK = ~CLK;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic clk_n(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    KEY_N = 2'b11;
    RST   = 1'b1;
    clk_n(2);
    RST   = 1'b0;
    exp_count = 3'd0;
  endtask

  task automatic test_reset();
    RST   = 1'b1;
    KEY_N = 2'b11;
    clk_n(2);
    checks++;
    if ({COUNT, STEP_PULSE, WRAP, AUTO_MODE} !== 6'b0) begin
      errors++;
      $display("FAIL reset_state: got %b required %b", {COUNT, STEP_PULSE, WRAP, AUTO_MODE}, 6'b0);
    end
    RST = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      clk_n(1);
      checks++;
      if ({COUNT, STEP_PULSE, WRAP, AUTO_MODE} !== 6'b0) begin
        errors++;
        $display("FAIL idle cycle %0d: got %b required %b", i, {COUNT, STEP_PULSE, WRAP, AUTO_MODE}, 6'b0);
      end
    end
    exp_count = 3'd0;
  endtask

  task automatic test_clean_press();
    KEY_N[0] = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      clk_n(1);
      if (i == 7) exp_count++;
      checks++;
      if (COUNT !== exp_count) begin
        errors++;
        $display("FAIL clean_count cycle %0d: got %0d required %0d", i, COUNT, exp_count);
      end
      checks++;
      if (STEP_PULSE !== (i == 7)) begin
        errors++;
        $display("FAIL clean_pulse cycle %0d: got %b required %b", i, STEP_PULSE, (i == 7));
      end
    end
    KEY_N[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clk_n(1);
      checks++;
      if ({COUNT, STEP_PULSE} !== {exp_count, 1'b0}) begin
        errors++;
        $display("FAIL release_no_step cycle %0d: got %b required %b", i, {COUNT, STEP_PULSE}, {exp_count, 1'b0});
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 1; i <= 20; i++) begin
      KEY_N[0] = (((i - 1) / 2) % 2) != 0;
      clk_n(1);
      checks++;
      if ({COUNT, STEP_PULSE} !== {exp_count, 1'b0}) begin
        errors++;
        $display("FAIL bounce cycle %0d: got %b required %b", i, {COUNT, STEP_PULSE}, {exp_count, 1'b0});
      end
    end
    KEY_N[0] = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clk_n(1);
      checks++;
      if ({COUNT, STEP_PULSE} !== {exp_count, 1'b0}) begin
        errors++;
        $display("FAIL bounce_settle cycle %0d: got %b required %b", i, {COUNT, STEP_PULSE}, {exp_count, 1'b0});
      end
    end
  endtask

  task automatic test_wrap();
    logic exp_wrap;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      KEY_N[0] = 1'b0;
      for (int i = 1; i <= 20; i++) begin
        if (i == 11) KEY_N[0] = 1'b1;
        clk_n(1);
        exp_wrap = (i == 7) && (exp_count == 3'd7);
        if (i == 7) exp_count++;
        checks++;
        if ({COUNT, STEP_PULSE, WRAP} !== {exp_count, (i == 7), exp_wrap}) begin
          errors++;
          $display("FAIL wrap press %0d cycle %0d: got cnt=%0d p=%b w=%b required cnt=%0d p=%b w=%b",
                   k, i, COUNT, STEP_PULSE, WRAP, exp_count, (i == 7), exp_wrap);
        end
      end
    end
    checks++;
    if (COUNT !== 3'd0) begin
      errors++;
      $display("FAIL wrap_final: got %0d required 0", COUNT);
    end
  endtask

  task automatic test_auto();
    logic exp_pulse, exp_wrap, exp_auto;
    for (int i = 1; i <= 100; i++) begin
      KEY_N[1] = !((i <= 60) || (i >= 71 && i <= 90));
      clk_n(1);
      exp_pulse = (i >= 17) && (i <= 77) && ((i - 7) % 10 == 0);
      exp_auto  = (i >= 7) && (i < 77);
      exp_wrap  = exp_pulse && (exp_count == 3'd7);
      if (exp_pulse) exp_count++;
      checks++;
      if ({COUNT, STEP_PULSE, WRAP, AUTO_MODE} !== {exp_count, exp_pulse, exp_wrap, exp_auto}) begin
        errors++;
        $display("FAIL auto cycle %0d: got cnt=%0d p=%b w=%b a=%b required cnt=%0d p=%b w=%b a=%b",
                 i, COUNT, STEP_PULSE, WRAP, AUTO_MODE, exp_count, exp_pulse, exp_wrap, exp_auto);
      end
    end
  endtask

  task automatic test_collision_reset();
    logic exp_pulse, exp_wrap;
    do_reset();
    for (int i = 1; i <= 60; i++) begin
      KEY_N[1] = !(i <= 20);
      KEY_N[0] = !(i >= 31 && i <= 45);
      clk_n(1);
      // Edge 37 carries both an auto tick and the manual press.
      exp_pulse = ((i >= 17) && ((i - 7) % 10 == 0)) || (i == 37);
      exp_wrap  = exp_pulse && (exp_count == 3'd7);
      if (exp_pulse) exp_count++;
      checks++;
      if ({COUNT, STEP_PULSE, WRAP, AUTO_MODE} !== {exp_count, exp_pulse, exp_wrap, (i >= 7)}) begin
        errors++;
        $display("FAIL collision cycle %0d: got cnt=%0d p=%b w=%b a=%b required cnt=%0d p=%b w=%b a=%b",
                 i, COUNT, STEP_PULSE, WRAP, AUTO_MODE, exp_count, exp_pulse, exp_wrap, (i >= 7));
      end
    end
    checks++;
    if (COUNT !== 3'd5) begin
      errors++;
      $display("FAIL collision_count_before_reset: got %0d required 5", COUNT);
    end
    RST = 1'b1;
    clk_n(1);
    checks++;
    if ({COUNT, STEP_PULSE, WRAP, AUTO_MODE} !== 6'b0) begin
      errors++;
      $display("FAIL mid_interval_reset: got %b required %b", {COUNT, STEP_PULSE, WRAP, AUTO_MODE}, 6'b0);
    end
    clk_n(1);
    RST = 1'b0;
    exp_count = 3'd0;
    for (int i = 1; i <= 15; i++) begin
      clk_n(1);
      checks++;
      if ({COUNT, STEP_PULSE, AUTO_MODE} !== 5'b0) begin
        errors++;
        $display("FAIL post_reset_quiet cycle %0d: got %b required %b", i, {COUNT, STEP_PULSE, AUTO_MODE}, 5'b0);
      end
    end
  endtask

  task automatic test_held_through_reset();
    KEY_N = 2'b10;
    RST   = 1'b1;
    clk_n(3);
    RST   = 1'b0;
    exp_count = 3'd0;
    for (int i = 1; i <= 15; i++) begin
      clk_n(1);
      if (i == 7) exp_count++;
      checks++;
      if ({COUNT, STEP_PULSE} !== {exp_count, (i == 7)}) begin
        errors++;
        $display("FAIL held_reset cycle %0d: got cnt=%0d p=%b required cnt=%0d p=%b",
                 i, COUNT, STEP_PULSE, exp_count, (i == 7));
      end
    end
    KEY_N = 2'b11;
    clk_n(10);
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_wrap();
    test_auto();
    test_collision_reset();
    test_held_through_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/key_step_counter.md
Name: key_step_counter

Overview:
- Upstream input stage for the LAB1 board top.
- Turns raw, bouncing, active-low push-buttons into a clean 3-bit stepping count that drives SW[2:0] of the downstream combinational lab logic.
- Replaces bench-driven stimulus on hardware.
- Supports manual single-step (KEY[0]) and a timed auto-step mode toggled by KEY[1]. Also gives strobes for LEDR indication.

Parameters:
- CNT_W, 3: width of COUNT; wraps modulo 2^CNT_W.
- DB_CYCLES, 500000: consecutive stable cycles needed to accept a key level change (10 ms at 50 MHz); must be >= 2.
- AUTO_CYCLES, 50000000: clock cycles between auto steps (1 s at 50 MHz); must be >= 2.

Ports:
- CLK  in  1  system clock (50 MHz board clock).
- RST  in  1  synchronous, active-high reset.
- KEY_N  in  2  raw push-buttons, active-low, asynchronous. [0] = step, [1] = auto-mode toggle.
- COUNT  out  CNT_W  current step value; feeds SW[CNT_W-1:0] downstream.
- STEP_PULSE  out  1  one-cycle strobe, high in the first cycle COUNT shows a new value.
- WRAP  out  1  one-cycle strobe coincident with STEP_PULSE when COUNT went from all-ones to 0.
- AUTO_MODE  out  1  1 = auto-step active.

Behaviour:
- Reset, with RST sampled high at a CLK edge:
  - COUNT=0, STEP_PULSE=0, WRAP=0, AUTO_MODE=0.
  - Sync flops=1, debounced levels=1 (released), debounce counters=0, auto timer=0.
  - RST overrides everything, including mid-debounce and mid-auto-interval.
- Synchroniser: 2 flops per key. The sync output lags KEY_N by 2 edges.
- Debounce, per key, independently:
  - The counter increments each cycle the sync output differs from the debounced level.
  - It clears to 0 in any cycle they agree, so any bounce restarts the count.
  - When the counter reaches DB_CYCLES-1 while still differing, the debounced level flips at the next edge and the counter clears.
- Press event: debounced level going 1->0 generates a one-cycle internal press. A release (0->1) generates nothing.
- Latency: KEY_N[0] goes low and stays low from edge E. COUNT and STEP_PULSE update at edge E+DB_CYCLES+3 (2 sync, DB_CYCLES debounce, 1 output register).
- Mode toggle: a KEY[1] press inverts AUTO_MODE, visible with the same latency. On any AUTO_MODE transition the auto timer clears to 0.
- Auto timer:
  - Runs only when AUTO_MODE=1 and counts 0..AUTO_CYCLES-1.
  - At AUTO_CYCLES-1 it issues an auto-tick and wraps to 0, so the first tick comes AUTO_CYCLES cycles after entering auto mode.
- Step sources: manual press (accepted in both modes) OR auto-tick.
  - If both occur in the same cycle, COUNT increments exactly once (+1, never +2).
- Arithmetic: COUNT <= COUNT+1 modulo 2^CNT_W. WRAP=1 only on the all-ones->0 step.
- Held key: one step only, with no auto-repeat. A new step requires release then re-press; the release must also pass debounce.
- Key held through reset: debounced level restarts at 1, so one press is registered DB_CYCLES+2 edges after RST deasserts.
- Simultaneous KEY[0] and KEY[1] press: the step and the mode toggle are both applied in the same cycle.

Decomposition:
- Shared package key_pkg: default constants (CLK_HZ=50000000, DB_CYCLES default, AUTO_CYCLES default), the key index constants KEY_STEP=0 and KEY_MODE=1, and a clog2-based counter-width helper.
- Sub-module key_debounce, instantiated once per key:
  - Contains the 2-flop synchroniser, debounce counter and debounced level.
  - Outputs level and press pulse.
  - Parameter DB_CYCLES.
- Timer, step logic and output registers live in key_step_counter.

Test Plan:
All scenarios use DB_CYCLES=4, AUTO_CYCLES=10.
- Reset/idle: RST high for 2 cycles, KEY_N=2'b11 for 50 cycles -> COUNT=0, STEP_PULSE/WRAP/AUTO_MODE=0 throughout.
- Clean press: KEY_N[0] low from edge E, held 20 cycles -> COUNT goes 0->1 and STEP_PULSE=1 exactly at edge E+7, single cycle. No further step while held.
- Bounce rejection: KEY_N[0] toggles low/high every 2 cycles for 20 cycles, then stays high -> COUNT unchanged, STEP_PULSE never asserted.
- Wrap: 8 clean press/release pairs, each phase 10 cycles -> COUNT sequence 1..7,0. WRAP=1 only together with the eighth STEP_PULSE.
- Auto mode: press KEY_N[1], then hold 60 cycles -> AUTO_MODE=1, and STEP_PULSE every 10 cycles with the first 10 cycles after AUTO_MODE rises. A second KEY[1] press -> AUTO_MODE=0 and ticks stop.
- Collision and reset: in auto mode, align a manual press so its press pulse lands in the auto-tick cycle -> COUNT +1 only. Then assert RST mid-interval with COUNT=5 -> all outputs zero at the next edge and AUTO_MODE=0.
